// File: rtl/usr_cmd_sequencer_if.sv
// Host-side command/response handshake bundle for usr_cmd_sequencer.
// master = host (VIO/CPU), slave = sequencer.
interface usr_cmd_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    localparam int SER_W = 2**CNT_W;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [SER_W-1:0] cmd_ser;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_rot;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_q;
    logic             busy;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_ser,
        output cmd_data, cmd_rot, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_q, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_ser,
        input  cmd_data, cmd_rot, rsp_ready,
        output cmd_ready, rsp_valid, rsp_q, busy
    );
endinterface

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer driving universal_shift_reg pins, returning q on a response.
// Optional macro USR_SEQ_ROTATE_EN: cmd_rot feeds serial-in from the end bit.
module usr_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    usr_cmd_sequencer_if.slave host,
    output logic               usr_rst,
    output logic [1:0]         usr_mode,
    output logic [WIDTH-1:0]   usr_data_in,
    output logic               usr_sr,
    output logic               usr_sl,
    input  logic [WIDTH-1:0]   usr_q
);
    localparam int SER_W = 2**CNT_W;

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_LD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       op_q, op_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] k_q, k_inc, k_n;
    logic [SER_W-1:0] ser_q, ser_n;
    logic [WIDTH-1:0] data_q, data_n;
    logic [WIDTH-1:0] rsp_q_r;
    logic             accept;
    logic             shift_q;
    logic             cmd_shift;
    logic             ser_bit;

    logic             rst_d;
    logic [1:0]       mode_d;
    logic [WIDTH-1:0] din_d;
    logic             sr_d;
    logic             sl_d;

`ifdef USR_SEQ_ROTATE_EN
    logic             rot_q, rot_n;
`endif

    assign accept    = (state == S_IDLE) && host.cmd_valid;
    assign shift_q   = op_q[0] ^ op_q[1];
    assign cmd_shift = host.cmd_op[0] ^ host.cmd_op[1];
    assign k_inc     = k_q + 1'b1;

    assign host.cmd_ready = (state == S_IDLE);
    assign host.busy      = (state != S_IDLE);
    assign host.rsp_valid = (state == S_RESP);
    assign host.rsp_q     = rsp_q_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (host.cmd_valid) begin
                    if (cmd_shift && host.cmd_cnt == '0) begin
                        state_nxt = S_SETTLE;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!shift_q || k_inc == cnt_q) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: state_nxt = S_RESP;
            S_RESP: begin
                if (host.rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pin values are computed for the cycle about to start, so the
    // accepting edge uses the live command and later edges the latch.
    always_comb begin
        op_n    = accept ? host.cmd_op : op_q;
        ser_n   = accept ? host.cmd_ser : ser_q;
        data_n  = accept ? host.cmd_data : data_q;
        k_n     = accept ? '0 : k_inc;
        ser_bit = ser_n[k_n];
`ifdef USR_SEQ_ROTATE_EN
        rot_n = accept ? host.cmd_rot : rot_q;
        // Mid-shift, usr_q is one step behind: predict the post-edge end bit.
        if (rot_n) begin
            if (op_n == OP_SHR) begin
                ser_bit = accept ? usr_q[0] : usr_q[1];
            end else begin
                ser_bit = accept ? usr_q[WIDTH-1] : usr_q[WIDTH-2];
            end
        end
`endif
        rst_d  = 1'b0;
        mode_d = 2'b00;
        din_d  = '0;
        sr_d   = 1'b0;
        sl_d   = 1'b0;
        if (state_nxt == S_RUN) begin
            unique case (op_n)
                OP_CLR: rst_d = 1'b1;
                OP_SHR: begin
                    mode_d = OP_SHR;
                    sr_d   = ser_bit;
                end
                OP_SHL: begin
                    mode_d = OP_SHL;
                    sl_d   = ser_bit;
                end
                OP_LD: begin
                    mode_d = OP_LD;
                    din_d  = data_n;
                end
                default: mode_d = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= 2'b00;
            cnt_q       <= '0;
            ser_q       <= '0;
            data_q      <= '0;
            k_q         <= '0;
            usr_rst     <= 1'b0;
            usr_mode    <= 2'b00;
            usr_data_in <= '0;
            usr_sr      <= 1'b0;
            usr_sl      <= 1'b0;
            rsp_q_r     <= '0;
`ifdef USR_SEQ_ROTATE_EN
            rot_q       <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_q   <= host.cmd_op;
                cnt_q  <= host.cmd_cnt;
                ser_q  <= host.cmd_ser;
                data_q <= host.cmd_data;
`ifdef USR_SEQ_ROTATE_EN
                rot_q  <= host.cmd_rot;
`endif
            end
            k_q         <= (state == S_RUN) ? k_inc : '0;
            usr_rst     <= rst_d;
            usr_mode    <= mode_d;
            usr_data_in <= din_d;
            usr_sr      <= sr_d;
            usr_sl      <= sl_d;
            if (state == S_SETTLE) begin
                rsp_q_r <= usr_q;
            end
        end
    end
endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Scoreboard bench for usr_cmd_sequencer with a behavioural shift register.
// Rotation cases are built in when USR_SEQ_ROTATE_EN is defined.
module tb_usr_cmd_sequencer;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int SER_W = 2**CNT_W;

`ifdef USR_SEQ_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usr_cmd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    logic             usr_rst;
    logic [1:0]       usr_mode;
    logic [WIDTH-1:0] usr_data_in;
    logic             usr_sr;
    logic             usr_sl;
    logic [WIDTH-1:0] usr_q;

    usr_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (bus.slave),
        .usr_rst     (usr_rst),
        .usr_mode    (usr_mode),
        .usr_data_in (usr_data_in),
        .usr_sr      (usr_sr),
        .usr_sl      (usr_sl),
        .usr_q       (usr_q)
    );

    // Plant: universal shift register
    logic [WIDTH-1:0] sreg = '0;
    always_ff @(posedge clk) begin
        if (usr_rst) sreg <= '0;
        else begin
            case (usr_mode)
                2'b01: sreg <= {usr_sr, sreg[WIDTH-1:1]};
                2'b10: sreg <= {sreg[WIDTH-2:0], usr_sl};
                2'b11: sreg <= usr_data_in;
                default: sreg <= sreg;
            endcase
        end
    end
    assign usr_q = sreg;

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] exp_reg = '0;
    logic [WIDTH-1:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                           input logic [SER_W-1:0] ser,
                           input logic [WIDTH-1:0] data,
                           input logic rot, input int hold);
        logic [WIDTH-1:0] r, held, exp_q;
        logic [31:0] pat, exp_pat;
        logic b, re, got;
        int exp_lat, exp_act, lat, act, bad, bad2;

        re = rot & ROT_EN;
        r = exp_reg;
        exp_pat = '0;
        case (op)
            2'b00: r = '0;
            2'b11: r = data;
            2'b01: for (int k = 0; k < int'(cnt); k++) begin
                b = re ? r[0] : ser[k];
                exp_pat[k] = b;
                r = {b, r[WIDTH-1:1]};
            end
            default: for (int k = 0; k < int'(cnt); k++) begin
                b = re ? r[WIDTH-1] : ser[k];
                exp_pat[k] = b;
                r = {r[WIDTH-2:0], b};
            end
        endcase
        exp_reg = r;
        sb_q.push_back(r);
        exp_act = (op == 2'b00 || op == 2'b11) ? 1 : int'(cnt);
        exp_lat = exp_act + 2;

        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_cnt   = cnt;
        bus.cmd_ser   = ser;
        bus.cmd_data  = data;
        bus.cmd_rot   = rot;
        bus.cmd_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.cmd_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk("accept", 32'(got), 1);
        if (!got) begin
            bus.cmd_valid = 1'b0;
            void'(sb_q.pop_back());
            return;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_cnt   = CNT_W'($urandom);
        bus.cmd_ser   = SER_W'($urandom);
        bus.cmd_data  = WIDTH'($urandom);
        bus.cmd_rot   = 1'($urandom);

        lat = 0; act = 0; bad = 0; pat = '0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) lat = c;
            else if (usr_mode != 2'b00 || usr_rst) begin
                act++;
                case (op)
                    2'b00: if (usr_mode != 2'b00 || usr_sr || usr_sl) bad++;
                    2'b11: if (usr_mode != 2'b11 || usr_rst ||
                               usr_data_in != data) bad++;
                    2'b01: begin
                        if (usr_mode != 2'b01 || usr_rst || usr_sl) bad++;
                        pat = pat | (32'(usr_sr) << (act - 1));
                    end
                    default: begin
                        if (usr_mode != 2'b10 || usr_rst || usr_sr) bad++;
                        pat = pat | (32'(usr_sl) << (act - 1));
                    end
                endcase
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("active_cycles", 32'(act), 32'(exp_act));
        chk("pin_values", 32'(bad), 0);
        if (op == 2'b01 || op == 2'b10) chk("serial_bits", pat, exp_pat);
        if (lat == 0) begin
            void'(sb_q.pop_back());
            return;
        end

        if (hold > 0) begin
            held = bus.rsp_q;
            bus.cmd_op    = 2'b11;
            bus.cmd_data  = ~exp_reg;
            bus.cmd_valid = 1'b1;
            bad2 = 0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!bus.rsp_valid || bus.rsp_q != held || bus.cmd_ready ||
                    !bus.busy || usr_mode != 2'b00) bad2++;
            end
            chk("hold_stable", 32'(bad2), 0);
            bus.cmd_valid = 1'b0;
        end

        bus.rsp_ready = 1'b1;
        chk("rsp_valid", 32'(bus.rsp_valid), 1);
        chk("sb_size", 32'(sb_q.size()), 1);
        if (sb_q.size() > 0) begin
            exp_q = sb_q.pop_front();
            chk("rsp_q", 32'(bus.rsp_q), 32'(exp_q));
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("back_idle", {29'd0, bus.busy, bus.cmd_ready, bus.rsp_valid},
            32'b010);
    endtask

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_cnt   = '0;
        bus.cmd_ser   = '0;
        bus.cmd_data  = '0;
        bus.cmd_rot   = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {17'd0, usr_rst, usr_mode, usr_data_in, usr_sr,
            usr_sl, bus.rsp_valid, bus.rsp_q, bus.busy}, 0);
        chk("reset_ready", 32'(bus.cmd_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_cmd(2'b11, 3'd0, 8'h00, 4'b1010, 1'b0, 0);
        run_cmd(2'b01, 3'd2, 8'b0000_0011, 4'h0, 1'b0, 0);
        run_cmd(2'b10, 3'd3, 8'b0000_0101, 4'h0, 1'b0, 0);
        run_cmd(2'b00, 3'd4, 8'hFF, 4'hF, 1'b0, 0);
        run_cmd(2'b01, 3'd0, 8'hFF, 4'h0, 1'b0, 0);
        run_cmd(2'b11, 3'd0, 8'h00, 4'b0110, 1'b0, 5);
        run_cmd(2'b10, 3'd7, 8'hA5, 4'h0, 1'b0, 1);
        run_cmd(2'b01, 3'd1, 8'h00, 4'h0, 1'b0, 0);

        // Abort a cnt=5 shift in its second RUN cycle
        @(negedge clk);
        bus.cmd_op    = 2'b01;
        bus.cmd_cnt   = 3'd5;
        bus.cmd_ser   = 8'b0001_0111;
        bus.cmd_data  = 4'h0;
        bus.cmd_rot   = 1'b0;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_mode", {30'd0, usr_mode}, 32'b01);
        exp_reg = {1'b1, exp_reg[WIDTH-1:1]};
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {17'd0, usr_rst, usr_mode, usr_data_in, usr_sr,
            usr_sl, bus.rsp_valid, bus.rsp_q, bus.busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.busy) n++;
        end
        chk("abort_no_rsp", 32'(n), 0);
        @(posedge clk);
        #1;
        run_cmd(2'b10, 3'd0, 8'h00, 4'h0, 1'b0, 0);

`ifdef USR_SEQ_ROTATE_EN
        run_cmd(2'b11, 3'd0, 8'h00, 4'b1001, 1'b0, 0);
        run_cmd(2'b01, 3'd1, 8'h00, 4'h0, 1'b1, 0);
        run_cmd(2'b10, 3'd3, 8'hFF, 4'h0, 1'b1, 0);
        run_cmd(2'b01, 3'd6, 8'h00, 4'h0, 1'b1, 0);
`endif

        for (int i = 0; i < 10; i++) begin
            run_cmd(2'($urandom_range(0, 3)), CNT_W'($urandom_range(0, 7)),
                    SER_W'($urandom), WIDTH'($urandom), 1'($urandom),
                    int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
